// File: rtl/pe_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg
//   Shared definitions for the weight-stationary MAC processing element.
//   - pe_mode_e : per-beat operating mode (systolic psum chain or local
//                 accumulate).
//   - acc_max / acc_min : signed range limits of an accumulator of a given
//                 width. The saturating stage-2 adder uses them when
//                 WS_PE_SAT_EN is defined.
// ---------------------------------------------------------------------------
package pe_pkg;

  typedef enum logic {
    MODE_SYS  = 1'b0,
    MODE_LACC = 1'b1
  } pe_mode_e;

  // Largest positive value of a width-bit two's complement number.
  function automatic logic signed [63:0] acc_max(input int unsigned width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Most negative value of a width-bit two's complement number.
  function automatic logic signed [63:0] acc_min(input int unsigned width);
    return ~acc_max(width);
  endfunction

endpackage

// File: rtl/pe_wbank.sv
// ---------------------------------------------------------------------------
// pe_wbank
//   W_DEPTH x W_BW weight register file for one PE.
//   Synchronous write and asynchronous read. Because the read sees only the
//   current register contents, a write to the entry being read only becomes
//   visible on the next cycle (read-before-write).
//
// Ports
//   clk      in  clock
//   rst_n    in  synchronous active-low reset, clears every entry
//   pe_en    in  0 = bank holds, writes are ignored
//   wr_en    in  write strobe
//   wr_addr  in  write address
//   wr_data  in  write data
//   rd_addr  in  read address (multiplier weight select)
//   rd_data  out read data, combinational from the register contents
// ---------------------------------------------------------------------------
module pe_wbank #(
  parameter int W_BW    = 8,
  parameter int W_DEPTH = 4,
  localparam int AW     = $clog2(W_DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pe_en,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [W_BW-1:0] wr_data,
  input  logic [AW-1:0]   rd_addr,
  output logic [W_BW-1:0] rd_data
);

  logic [W_BW-1:0] bank_q [W_DEPTH];
  logic [W_BW-1:0] bank_d [W_DEPTH];

  // Next-state of the bank: hold everything, overwrite one entry on a write.
  always_comb begin
    bank_d = bank_q;
    if (wr_en) begin
      bank_d[wr_addr] = wr_data;
    end
  end

  // Bank registers, reset to zero and frozen while the PE is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_q <= '{default: '0};
    end else if (pe_en) begin
      bank_q <= bank_d;
    end
  end

  assign rd_data = bank_q[rd_addr];

endmodule

// File: rtl/ws_mac_pe.sv
// ---------------------------------------------------------------------------
// ws_mac_pe
//   Weight-stationary multiply-accumulate processing element for a systolic
//   array. Feature maps pass horizontally with 1-cycle latency, partial sums
//   pass vertically with 2-cycle latency. A W_DEPTH-entry weight bank is
//   loaded over a daisy-chained weight bus. Local-accumulate mode lets the
//   PE behave output-stationary: products are summed internally and one
//   result is emitted on the last beat of each group.
//
// Configuration macro
//   WS_PE_SAT_EN  defined   : stage-2 sums saturate to the ACC_BW signed
//                             range; any clamp sets the sticky o_sat.
//                 undefined : sums wrap modulo 2^ACC_BW, o_sat is tied 0.
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   pe_en                         0 = every register holds
//   w_load, w_addr, i_weight      weight bank write
//   o_w_load, o_w_addr, o_weight  weight bus to next PE (1-cycle register)
//   w_sel                         bank entry for this beat's multiply
//   i_mode                        0 = systolic, 1 = local accumulate
//   i_valid, i_last               beat valid, last beat of a local group
//   i_fmap, i_psum                feature input, partial sum from above
//   o_valid, o_fmap               feature pass-through (1-cycle register)
//   o_psum_valid, o_psum          result (2-cycle latency)
//   o_sat                         sticky saturation flag
// ---------------------------------------------------------------------------
module ws_mac_pe
  import pe_pkg::*;
#(
  parameter int I_F_BW  = 8,
  parameter int W_BW    = 8,
  parameter int ACC_BW  = 24,
  parameter int W_DEPTH = 4,
  localparam int AW     = $clog2(W_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pe_en,
  input  logic              w_load,
  input  logic [AW-1:0]     w_addr,
  input  logic [W_BW-1:0]   i_weight,
  output logic              o_w_load,
  output logic [AW-1:0]     o_w_addr,
  output logic [W_BW-1:0]   o_weight,
  input  logic [AW-1:0]     w_sel,
  input  logic              i_mode,
  input  logic              i_valid,
  input  logic              i_last,
  input  logic [I_F_BW-1:0] i_fmap,
  input  logic [ACC_BW-1:0] i_psum,
  output logic              o_valid,
  output logic [I_F_BW-1:0] o_fmap,
  output logic              o_psum_valid,
  output logic [ACC_BW-1:0] o_psum,
  output logic              o_sat
);

  localparam int P_BW = I_F_BW + W_BW;

  // Reject parameter sets the datapath cannot represent.
  if (ACC_BW < P_BW) begin : g_acc_bw_check
    $error("ws_mac_pe: ACC_BW must be at least I_F_BW+W_BW");
  end
  if (W_DEPTH < 2) begin : g_depth_check
    $error("ws_mac_pe: W_DEPTH must be at least 2");
  end

  // Weight bus and fmap pass-through registers.
  logic              w_load_q,  w_load_d;
  logic [AW-1:0]     w_addr_q,  w_addr_d;
  logic [W_BW-1:0]   weight_q,  weight_d;
  logic              valid_q,   valid_d;
  logic [I_F_BW-1:0] fmap_q,    fmap_d;

  // Stage 1 registers.
  logic signed [P_BW-1:0]   prod_q,  prod_d;
  logic signed [ACC_BW-1:0] psum_q,  psum_d;
  logic                     v1_q,    v1_d;
  pe_mode_e                 mode1_q, mode1_d;
  logic                     last1_q, last1_d;

  // Stage 2 registers.
  logic signed [ACC_BW-1:0] acc_q,        acc_d;
  logic signed [ACC_BW-1:0] o_psum_q,     o_psum_d;
  logic                     psum_valid_q, psum_valid_d;

  logic [W_BW-1:0]          bank_rd;
  logic signed [P_BW-1:0]   fmap_ext;
  logic signed [P_BW-1:0]   wgt_ext;
  logic signed [ACC_BW-1:0] prod_ext;
  logic signed [ACC_BW-1:0] sum_base;
  logic signed [ACC_BW-1:0] sum;

  pe_wbank #(
    .W_BW    (W_BW),
    .W_DEPTH (W_DEPTH)
  ) u_wbank (
    .clk     (clk),
    .rst_n   (rst_n),
    .pe_en   (pe_en),
    .wr_en   (w_load),
    .wr_addr (w_addr),
    .wr_data (i_weight),
    .rd_addr (w_sel),
    .rd_data (bank_rd)
  );

  // Weight bus, fmap pass and stage 1 next-state. The bank read is taken
  // from the registered contents, so a same-cycle load to w_sel is not seen.
  always_comb begin
    w_load_d = w_load;
    w_addr_d = w_addr;
    weight_d = i_weight;
    valid_d  = i_valid;
    fmap_d   = i_fmap;

    fmap_ext = P_BW'($signed(i_fmap));
    wgt_ext  = P_BW'($signed(bank_rd));
    prod_d   = fmap_ext * wgt_ext;
    psum_d   = $signed(i_psum);
    v1_d     = i_valid;
    mode1_d  = pe_mode_e'(i_mode);
    last1_d  = i_last;
  end

  // Stage 2 adder: the systolic chain adds to the upstream psum, local
  // accumulate adds to the private accumulator. Only one of them is used
  // per beat, so a single adder is shared.
  assign prod_ext = ACC_BW'(prod_q);
  assign sum_base = (mode1_q == MODE_LACC) ? acc_q : psum_q;

`ifdef WS_PE_SAT_EN
  localparam logic [ACC_BW-1:0] ACC_MAX = ACC_BW'(acc_max(ACC_BW));
  localparam logic [ACC_BW-1:0] ACC_MIN = ACC_BW'(acc_min(ACC_BW));

  logic signed [ACC_BW:0] sum_wide;
  logic                   clamp;
  logic                   sat_q, sat_d;

  // One guard bit catches overflow: the top two bits disagree exactly when
  // the true sum is outside the ACC_BW range, and the guard bit gives the
  // direction of the clamp.
  always_comb begin
    sum_wide = (ACC_BW + 1)'(sum_base) + (ACC_BW + 1)'(prod_ext);
    clamp    = sum_wide[ACC_BW] != sum_wide[ACC_BW-1];
    if (clamp) begin
      sum = sum_wide[ACC_BW] ? ACC_MIN : ACC_MAX;
    end else begin
      sum = sum_wide[ACC_BW-1:0];
    end
  end
`else
  assign sum = sum_base + prod_ext;
`endif

  // Stage 2 next-state. Systolic beats always emit; local-accumulate beats
  // emit only on the last beat of the group, which also restarts acc.
  // A systolic beat never touches acc, so a group survives a mode change.
  always_comb begin
    acc_d        = acc_q;
    o_psum_d     = o_psum_q;
    psum_valid_d = 1'b0;
`ifdef WS_PE_SAT_EN
    sat_d        = sat_q;
`endif
    if (v1_q) begin
`ifdef WS_PE_SAT_EN
      sat_d = sat_q | clamp;
`endif
      if (mode1_q == MODE_SYS) begin
        o_psum_d     = sum;
        psum_valid_d = 1'b1;
      end else if (last1_q) begin
        o_psum_d     = sum;
        psum_valid_d = 1'b1;
        acc_d        = '0;
      end else begin
        acc_d = sum;
      end
    end
  end

  // All PE registers: reset clears, pe_en low freezes everything so a stall
  // neither drops nor duplicates a beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_load_q     <= 1'b0;
      w_addr_q     <= '0;
      weight_q     <= '0;
      valid_q      <= 1'b0;
      fmap_q       <= '0;
      prod_q       <= '0;
      psum_q       <= '0;
      v1_q         <= 1'b0;
      mode1_q      <= MODE_SYS;
      last1_q      <= 1'b0;
      acc_q        <= '0;
      o_psum_q     <= '0;
      psum_valid_q <= 1'b0;
`ifdef WS_PE_SAT_EN
      sat_q        <= 1'b0;
`endif
    end else if (pe_en) begin
      w_load_q     <= w_load_d;
      w_addr_q     <= w_addr_d;
      weight_q     <= weight_d;
      valid_q      <= valid_d;
      fmap_q       <= fmap_d;
      prod_q       <= prod_d;
      psum_q       <= psum_d;
      v1_q         <= v1_d;
      mode1_q      <= mode1_d;
      last1_q      <= last1_d;
      acc_q        <= acc_d;
      o_psum_q     <= o_psum_d;
      psum_valid_q <= psum_valid_d;
`ifdef WS_PE_SAT_EN
      sat_q        <= sat_d;
`endif
    end
  end

  assign o_w_load     = w_load_q;
  assign o_w_addr     = w_addr_q;
  assign o_weight     = weight_q;
  assign o_valid      = valid_q;
  assign o_fmap       = fmap_q;
  assign o_psum_valid = psum_valid_q;
  assign o_psum       = o_psum_q;
`ifdef WS_PE_SAT_EN
  assign o_sat        = sat_q;
`else
  assign o_sat        = 1'b0;
`endif

endmodule

// File: tb/tb_ws_mac_pe.sv
// ---------------------------------------------------------------------------
// tb_ws_mac_pe
//   Directed testbench for ws_mac_pe with ACC_BW=16 so overflow can be
//   exercised. Inputs change 1 time unit after the rising clock edge and
//   outputs are compared at that same point, well away from the edge.
//   Expected values are hand-computed; the overflow expectations follow
//   WS_PE_SAT_EN.
// ---------------------------------------------------------------------------
module tb_ws_mac_pe;

  localparam int I_F_BW  = 8;
  localparam int W_BW    = 8;
  localparam int ACC_BW  = 16;
  localparam int W_DEPTH = 4;
  localparam int AW      = 2;

  logic              clk;
  logic              rst_n;
  logic              pe_en;
  logic              w_load;
  logic [AW-1:0]     w_addr;
  logic [W_BW-1:0]   i_weight;
  logic              o_w_load;
  logic [AW-1:0]     o_w_addr;
  logic [W_BW-1:0]   o_weight;
  logic [AW-1:0]     w_sel;
  logic              i_mode;
  logic              i_valid;
  logic              i_last;
  logic [I_F_BW-1:0] i_fmap;
  logic [ACC_BW-1:0] i_psum;
  logic              o_valid;
  logic [I_F_BW-1:0] o_fmap;
  logic              o_psum_valid;
  logic [ACC_BW-1:0] o_psum;
  logic              o_sat;

  int checks = 0;
  int errors = 0;

  ws_mac_pe #(
    .I_F_BW  (I_F_BW),
    .W_BW    (W_BW),
    .ACC_BW  (ACC_BW),
    .W_DEPTH (W_DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pe_en        (pe_en),
    .w_load       (w_load),
    .w_addr       (w_addr),
    .i_weight     (i_weight),
    .o_w_load     (o_w_load),
    .o_w_addr     (o_w_addr),
    .o_weight     (o_weight),
    .w_sel        (w_sel),
    .i_mode       (i_mode),
    .i_valid      (i_valid),
    .i_last       (i_last),
    .i_fmap       (i_fmap),
    .i_psum       (i_psum),
    .o_valid      (o_valid),
    .o_fmap       (o_fmap),
    .o_psum_valid (o_psum_valid),
    .o_psum       (o_psum),
    .o_sat        (o_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] p8(input int v);
    return v[7:0];
  endfunction

  function automatic logic [15:0] p16(input int v);
    return v[15:0];
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic mode,
                               input logic last, input logic [AW-1:0] sel,
                               input logic [I_F_BW-1:0] fmap,
                               input logic [ACC_BW-1:0] psum);
    i_valid = valid;
    i_mode  = mode;
    i_last  = last;
    w_sel   = sel;
    i_fmap  = fmap;
    i_psum  = psum;
  endtask

  task automatic loadWeight(input logic [AW-1:0] addr, input logic [W_BW-1:0] data);
    w_load   = 1'b1;
    w_addr   = addr;
    i_weight = data;
    tick();
  endtask

  initial begin
    rst_n    = 1'b0;
    pe_en    = 1'b1;
    w_load   = 1'b0;
    w_addr   = '0;
    i_weight = '0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // Reset state
    checkOutput("rst_psum", o_psum, 0);
    checkOutput("rst_psum_valid", o_psum_valid, 0);
    checkOutput("rst_valid", o_valid, 0);
    checkOutput("rst_fmap", o_fmap, 0);
    checkOutput("rst_weight", o_weight, 0);
    checkOutput("rst_sat", o_sat, 0);

    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("idle_psum_valid", o_psum_valid, 0);
    end

    // Weight loads: bank = {4, -3, 2, 1}
    loadWeight(1, p8(-3));
    checkOutput("wbus_load", o_w_load, 1);
    checkOutput("wbus_addr", o_w_addr, 1);
    checkOutput("wbus_data", o_weight, p8(-3));
    loadWeight(2, 2);
    loadWeight(0, 4);
    loadWeight(3, 1);
    w_load = 1'b0;
    tick();
    checkOutput("wbus_load_off", o_w_load, 0);

    // Systolic beat: 100 + 7*(-3) = 79
    applyStimulus(1, 0, 0, 1, 7, 100);
    tick();
    checkOutput("sys_fmap", o_fmap, 7);
    checkOutput("sys_valid", o_valid, 1);
    checkOutput("sys_psum_valid_early", o_psum_valid, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("sys_psum_valid", o_psum_valid, 1);
    checkOutput("sys_psum", o_psum, 79);
    tick();
    checkOutput("sys_psum_valid_drop", o_psum_valid, 0);

    // Local accumulate, weight 2: 2*(1+2+3+4) = 20, then 2*(5+5) = 20
    applyStimulus(1, 1, 0, 2, 1, 0);
    tick();
    checkOutput("lacc_v0", o_psum_valid, 0);
    applyStimulus(1, 1, 0, 2, 2, 0);
    tick();
    checkOutput("lacc_v1", o_psum_valid, 0);
    applyStimulus(1, 1, 0, 2, 3, 0);
    tick();
    checkOutput("lacc_v2", o_psum_valid, 0);
    applyStimulus(1, 1, 1, 2, 4, 0);
    tick();
    checkOutput("lacc_v3", o_psum_valid, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("lacc_g1_valid", o_psum_valid, 1);
    checkOutput("lacc_g1_psum", o_psum, 20);
    tick();
    checkOutput("lacc_g1_once", o_psum_valid, 0);
    applyStimulus(1, 1, 0, 2, 5, 0);
    tick();
    applyStimulus(1, 1, 1, 2, 5, 0);
    tick();
    checkOutput("lacc_g2_v0", o_psum_valid, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("lacc_g2_valid", o_psum_valid, 1);
    checkOutput("lacc_g2_psum", o_psum, 20);

    // Mode change mid-group: acc=2, systolic 50+2=52, then acc 2+2=4
    applyStimulus(1, 1, 0, 2, 1, 0);
    tick();
    applyStimulus(1, 0, 0, 2, 1, 50);
    tick();
    applyStimulus(1, 1, 1, 2, 1, 0);
    tick();
    checkOutput("mix_sys_psum", o_psum, 52);
    checkOutput("mix_sys_valid", o_psum_valid, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("mix_lacc_psum", o_psum, 4);
    checkOutput("mix_lacc_valid", o_psum_valid, 1);
    tick();

    // Stall: beats (1,10)->7, (2,20)->14, (3,30)->21 with weight -3
    applyStimulus(1, 0, 0, 1, 1, 10);
    tick();
    applyStimulus(1, 0, 0, 1, 2, 20);
    tick();
    checkOutput("stall_pre_psum", o_psum, 7);
    pe_en = 1'b0;
    applyStimulus(1, 1, 1, 0, 99, 999);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_psum", o_psum, 7);
      checkOutput("stall_psum_valid", o_psum_valid, 1);
      checkOutput("stall_fmap", o_fmap, 2);
    end
    pe_en = 1'b1;
    applyStimulus(1, 0, 0, 1, 3, 30);
    tick();
    checkOutput("resume_psum_b", o_psum, 14);
    checkOutput("resume_fmap", o_fmap, 3);
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("resume_psum_c", o_psum, 21);
    checkOutput("resume_valid_c", o_psum_valid, 1);
    tick();
    checkOutput("resume_drain", o_psum_valid, 0);

    // Load collision: bank[0]=4 overwritten with 9 in the beat's own cycle
    w_load   = 1'b1;
    w_addr   = 0;
    i_weight = 9;
    applyStimulus(1, 0, 0, 0, 1, 0);
    tick();
    w_load = 1'b0;
    applyStimulus(1, 0, 0, 0, 1, 0);
    tick();
    checkOutput("collide_old", o_psum, 4);
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("collide_new", o_psum, 9);

    // Overflow at ACC_BW=16 with weight 1
    applyStimulus(1, 0, 0, 3, p8(127), 16'h7FFF);
    tick();
    applyStimulus(1, 0, 0, 3, p8(-128), 16'h8000);
    tick();
`ifdef WS_PE_SAT_EN
    checkOutput("ovf_pos_psum", o_psum, p16(32767));
    checkOutput("ovf_pos_sat", o_sat, 1);
`else
    checkOutput("ovf_pos_psum", o_psum, p16(-32642));
    checkOutput("ovf_pos_sat", o_sat, 0);
`endif
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
`ifdef WS_PE_SAT_EN
    checkOutput("ovf_neg_psum", o_psum, p16(-32768));
`else
    checkOutput("ovf_neg_psum", o_psum, p16(32640));
`endif
    // In-range beat afterwards: o_sat must remain as it was
    applyStimulus(1, 0, 0, 3, 1, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("post_ovf_psum", o_psum, 2);
`ifdef WS_PE_SAT_EN
    checkOutput("sat_sticky", o_sat, 1);
`else
    checkOutput("sat_sticky", o_sat, 0);
`endif

    // Reset mid-group discards acc and clears o_sat
    loadWeight(2, 2);
    w_load = 1'b0;
    applyStimulus(1, 1, 0, 2, 3, 0);
    tick();
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("midrst_sat", o_sat, 0);
    checkOutput("midrst_psum", o_psum, 0);
    checkOutput("midrst_valid", o_psum_valid, 0);
    rst_n = 1'b1;
    loadWeight(2, 2);
    w_load = 1'b0;
    applyStimulus(1, 1, 1, 2, 3, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("midrst_group_psum", o_psum, 6);
    checkOutput("midrst_group_valid", o_psum_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
